muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencing controller for the RV32M unit in the EX stage. Accepts M-extension requests over a valid/ready handshake, computes multiplies in one registered cycle, drives an iterative unsigned divider for DIV/DIVU/REM/REMU, and resolves the architectural corner cases (divide-by-zero, signed overflow) without iterating. It caches the last division so a DIV/REM pair on identical operands costs one divide. It holds each result until the writeback side takes it, and supports pipeline flush.

## Interface
Parameters:
- XLEN, riscv_pkg::XLEN (32): operand/result width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  alu_op_e  one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- req_a, req_b  in  XLEN  rs1/rs2 operands.
- req_rd  in  5  destination tag, returned unchanged.
- flush  in  1  kill in-flight and pending work.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  XLEN  result.
- rsp_rd  out  5  tag of result.
- busy  out  1  high in DIV state (hazard/stall input).

## Operation
- States: IDLE, DIV, DONE.
- req_ready = reset high and (state==IDLE or (state==DONE and rsp_ready)) and not flush.
- On accept:
  - MUL* -> compute 2*XLEN product, select low half (MUL) or high half (MULH s×s, MULHSU s×u, MULHU u×u), register it, go to DONE.
  - DIV*/REM* -> fast-path check, in priority order:
    1. b==0: quotient all-ones, remainder = a.
    2. Signed op with a==0x80000000 and b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
    3. Cache hit: cache valid and a, b and signedness all match. Return cached quotient or remainder.
  - Any fast path -> DONE. Otherwise load |a|, |b| (magnitudes only for signed ops) into div_iter, pulse start, go to DIV.
- DIV: wait for div_iter done.
  - Sign fix for signed ops: quotient is negated when operand signs differ; remainder takes the sign of a.
  - Write the selected result, write the cache (a, b, signed, quotient, remainder, valid=1), go to DONE.
- DONE: rsp_valid=1. rsp_result and rsp_rd stay stable until rsp_ready.
  - rsp_ready with no new request -> IDLE.
  - rsp_ready with a simultaneous accept -> handled exactly as an accept from IDLE.
- Fast-path results never write the cache.
- flush (any state): next state IDLE, rsp_valid deasserts next cycle, div_iter aborted, cache not written. Flush in the same cycle as req_valid: request dropped. Flush in the same cycle as rsp_ready: response treated as dropped.
- Non-M req_op: protocol violation. Respond with 0 after 1 cycle and leave the cache unchanged.

## Timing
- Accept in cycle N:
  - MUL*, fast-path div, cache hit: rsp_valid in N+1.
  - Iterating div: div_iter runs N+1..N+XLEN, rsp_valid in N+XLEN+1.
- Throughput with rsp_ready held high: one MUL per cycle. Divides stall for their full latency.
- busy is high exactly in DIV state.
- Reset (sampled low on a clk edge): state IDLE, rsp_valid=0, rsp_result=0, rsp_rd=0, busy=0, cache valid=0, div_iter idle. req_ready=0 while reset is low.
- Reset mid-divide: abort, no response, cache not written.

## Structure
- riscv_pkg gains:
  - muldiv_state_e {IDLE, DIV, DONE}.
  - Functions is_div_op(alu_op_e), is_signed_div(alu_op_e) and wants_rem(alu_op_e).
- Sub-module div_iter: radix-2 restoring, unsigned, XLEN iterations.
  - Ports: clk, reset, start, abort, dividend, divisor, busy, done (1-cycle pulse), quotient, remainder.
- Sign handling, fast paths, cache and handshake live in muldiv_ctrl.

## Test plan
- MUL 10×5 -> 50; MULH 0x80000000×2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. Each rsp_valid one cycle after accept. Back-to-back issue with rsp_ready=1 sustains one per cycle.
- DIV −20/3 -> 0xFFFFFFFA with rsp_valid at N+33 and busy high for 32 cycles. An immediately following REM −20,3 -> 0xFFFFFFFE at N'+1 (cache hit).
- DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/−1 -> 0x80000000; REM same operands -> 0. All return in 1 cycle, busy never set.
- Backpressure: hold rsp_ready=0 for 5 cycles after DIVU 100/10. rsp_result stays 10, rsp_rd stays stable, req_ready=0 throughout.
- Flush at cycle N+10 of DIV 20/3: rsp_valid never rises. A following REM 20,3 iterates the full 32 cycles (cache not written) and returns 2.
- Reset (low) at cycle N+5 of a divide: all outputs 0 next cycle. After release, MUL 100×100 -> 10000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 types for the EX-stage M-extension unit: ALU opcodes,
// muldiv sequencer states and opcode classification helpers.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } muldiv_state_e;

    // Per-divide bookkeeping carried while the iterative divider runs
    typedef struct packed {
        logic rem;    // return remainder rather than quotient
        logic sgn;    // signed operation
        logic neg_q;  // negate quotient on completion
        logic neg_r;  // negate remainder on completion
    } div_pend_t;

    function automatic logic is_mul_op(input alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_signed_div(input alu_op_e op);
        return op inside {ALU_DIV, ALU_REM};
    endfunction

    function automatic logic wants_rem(input alu_op_e op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response handshake bundle between the EX stage and muldiv_ctrl.
//   req_*  : valid/ready request carrying op, operands and destination tag
//   rsp_*  : valid/ready response carrying result and destination tag
interface muldiv_ctrl_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic                req_valid;
    logic                req_ready;
    alu_op_e             req_op;
    logic [XLEN-1:0]     req_a;
    logic [XLEN-1:0]     req_b;
    logic [REG_AW-1:0]   req_rd;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_result;
    logic [REG_AW-1:0]   rsp_rd;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_rd
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_rd
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle, XLEN cycles.
//   clk, reset (sync, active-low), start/abort : control
//   dividend, divisor : operands captured on start
//   busy : iterating; done : pulses in the final iteration cycle
//   quotient, remainder : valid while done is high (final step result)
module div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] q_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   part;
    logic            ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] q_step;

    // One restoring step: shift next dividend bit into the partial remainder
    always_comb begin
        part     = {rem_q, q_q[XLEN-1]};
        ge       = (part >= {1'b0, dvs_q});
        rem_step = ge ? XLEN'(part - {1'b0, dvs_q}) : part[XLEN-1:0];
        q_step   = {q_q[XLEN-2:0], ge};
    end

    // Final step result is presented combinationally so the caller can
    // capture it on the same edge that ends the last iteration
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = q_step;
    assign remainder = rem_step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            q_q    <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            q_q    <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            q_q   <= q_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencing controller: single-cycle multiply, iterative divide with
// architectural corner-case fast paths and a one-entry last-divide cache.
//   clk, reset (sync, active-low)
//   bus   : request/response handshake (slave side)
//   flush : kill in-flight and pending work
//   busy  : high while a divide iterates
module muldiv_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus,
    input  logic         flush,
    output logic         busy
);
    localparam int unsigned   PW      = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    div_pend_t         pend_q, pend_d;
    logic [XLEN-1:0]   pa_q, pa_d, pb_q, pb_d;

    // Last-divide cache (sign-corrected results)
    logic              cv_q, cv_d, cs_q, cs_d;
    logic [XLEN-1:0]   ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;

    logic              accept;
    logic              req_sgn;
    logic              cache_hit;
    logic              div_start, div_busy, div_done, div_fin;
    logic [XLEN-1:0]   div_a, div_b, div_q, div_r;
    logic [XLEN-1:0]   fix_q, fix_r;
    logic [PW-1:0]     ext_a, ext_b, prod;
    logic [XLEN-1:0]   mul_res;

    assign bus.req_ready  = reset && !flush &&
                            ((state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready));
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = res_q;
    assign bus.rsp_rd     = rd_q;
    assign busy           = (state_q == DIV);

    // Multiply: extend each operand per its signedness, keep the wanted half
    always_comb begin
        ext_a = (bus.req_op inside {ALU_MULH, ALU_MULHSU})
              ? {{XLEN{bus.req_a[XLEN-1]}}, bus.req_a} : {{XLEN{1'b0}}, bus.req_a};
        ext_b = (bus.req_op == ALU_MULH)
              ? {{XLEN{bus.req_b[XLEN-1]}}, bus.req_b} : {{XLEN{1'b0}}, bus.req_b};
        prod    = ext_a * ext_b;
        mul_res = (bus.req_op == ALU_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end

    // Divide operand conditioning and cache lookup
    always_comb begin
        req_sgn   = is_signed_div(bus.req_op);
        div_a     = (req_sgn && bus.req_a[XLEN-1]) ? -bus.req_a : bus.req_a;
        div_b     = (req_sgn && bus.req_b[XLEN-1]) ? -bus.req_b : bus.req_b;
        cache_hit = cv_q && (ca_q == bus.req_a) && (cb_q == bus.req_b) && (cs_q == req_sgn);
        fix_q     = pend_q.neg_q ? -div_q : div_q;
        fix_r     = pend_q.neg_r ? -div_r : div_r;
        div_fin   = div_busy && div_done;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        rd_d      = rd_q;
        pend_d    = pend_q;
        pa_d      = pa_q;
        pb_d      = pb_q;
        cv_d      = cv_q;
        cs_d      = cs_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        cq_d      = cq_q;
        cr_d      = cr_q;
        div_start = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                DIV: begin
                    if (div_fin) begin
                        res_d   = pend_q.rem ? fix_r : fix_q;
                        cv_d    = 1'b1;
                        cs_d    = pend_q.sgn;
                        ca_d    = pa_q;
                        cb_d    = pb_q;
                        cq_d    = fix_q;
                        cr_d    = fix_r;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            // Accept is only possible from IDLE or a consumed DONE
            if (accept) begin
                rd_d    = bus.req_rd;
                state_d = DONE;
                if (is_mul_op(bus.req_op)) begin
                    res_d = mul_res;
                end else if (is_div_op(bus.req_op)) begin
                    if (bus.req_b == '0) begin
                        res_d = wants_rem(bus.req_op) ? bus.req_a : '1;
                    end else if (req_sgn && (bus.req_a == INT_MIN) && (bus.req_b == '1)) begin
                        res_d = wants_rem(bus.req_op) ? '0 : INT_MIN;
                    end else if (cache_hit) begin
                        res_d = wants_rem(bus.req_op) ? cr_q : cq_q;
                    end else begin
                        div_start    = 1'b1;
                        pa_d         = bus.req_a;
                        pb_d         = bus.req_b;
                        pend_d.rem   = wants_rem(bus.req_op);
                        pend_d.sgn   = req_sgn;
                        pend_d.neg_q = req_sgn && (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
                        pend_d.neg_r = req_sgn && bus.req_a[XLEN-1];
                        state_d      = DIV;
                    end
                end else begin
                    res_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            rd_q    <= '0;
            pend_q  <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            cv_q    <= 1'b0;
            cs_q    <= 1'b0;
            ca_q    <= '0;
            cb_q    <= '0;
            cq_q    <= '0;
            cr_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            cv_q    <= cv_d;
            cs_q    <= cs_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            cq_q    <= cq_d;
            cr_q    <= cr_d;
        end
    end

    div_iter #(
        .XLEN(XLEN)
    ) u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (flush),
        .dividend  (div_a),
        .divisor   (div_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );
endmodule
